// File: rtl/wall_ctrl_multi_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wall_ctrl_multi_if                                                   |
// | Draw-job handshake between the wall controller and the pixel drawer. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface wall_ctrl_multi_if #(
  parameter int ID_W  = 2,
  parameter int POS_W = 8
);
  logic             draw_req;
  logic [ID_W-1:0]  draw_id;
  logic [POS_W-1:0] draw_x;
  logic             draw_erase;
  logic             draw_done;

  modport master (
    output draw_req, draw_id, draw_x, draw_erase,
    input  draw_done
  );

  modport slave (
    input  draw_req, draw_id, draw_x, draw_erase,
    output draw_done
  );
endinterface
`default_nettype wire

// File: rtl/wall_ctrl_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wall_ctrl_multi                                                      |
// | NUM_WALLS wall FSMs sharing one round-robin arbitrated draw port.    |
// | Optional macro WALL_ERASE_EN adds an erase job before every move.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module wall_ctrl_multi #(
  parameter int NUM_WALLS = 4,
  parameter int ID_W      = 2,
  parameter int POS_W     = 8,
  parameter int POS_MAX   = 159,
  parameter int STEP      = 4
) (
  input  wire logic                       clk,
  input  wire logic                       resetn,
  input  wire logic [NUM_WALLS-1:0]       go,
  input  wire logic [NUM_WALLS-1:0]       touched,
  input  wire logic                       tick,
  input  wire logic                       restart,
  wall_ctrl_multi_if.master               drw,
  output logic      [4*NUM_WALLS-1:0]     state_flat,
  output logic      [POS_W*NUM_WALLS-1:0] pos_flat,
  output logic                            all_stopped
);

  typedef enum logic [3:0] {
    S_READY = 4'b0101,
    S_MOVE  = 4'b0110,
    S_STOP  = 4'b0111,
    S_DRAW  = 4'b1000
`ifdef WALL_ERASE_EN
    , S_ERASE = 4'b1001
`endif
  } state_t;

  localparam logic [POS_W-1:0] C_POS_MAX = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] C_STEP    = POS_W'(STEP);
  localparam logic [ID_W-1:0]  C_RR_INIT = ID_W'(NUM_WALLS - 1);

  state_t           r_state    [NUM_WALLS];
  state_t           w_state_nx [NUM_WALLS];
  state_t           r_after    [NUM_WALLS];
  state_t           w_after_nx [NUM_WALLS];
  logic [POS_W-1:0] r_pos      [NUM_WALLS];
  logic [POS_W-1:0] w_pos_nx   [NUM_WALLS];
  logic [NUM_WALLS-1:0] r_hit;
  logic [NUM_WALLS-1:0] w_hit_nx;
`ifdef WALL_ERASE_EN
  logic [POS_W-1:0] r_old_pos    [NUM_WALLS];
  logic [POS_W-1:0] w_old_pos_nx [NUM_WALLS];
`endif

  logic [NUM_WALLS-1:0] w_busy;
  logic [NUM_WALLS-1:0] w_stop;
  logic [NUM_WALLS-1:0] w_done;

  logic             r_req;
  logic [ID_W-1:0]  r_id;
  logic [POS_W-1:0] r_x;
  logic [ID_W-1:0]  r_rr;
  logic             w_found;
  logic [ID_W-1:0]  w_pick;
  logic [POS_W-1:0] w_pick_x;
  int               w_idx;
`ifdef WALL_ERASE_EN
  logic             r_erase;
  logic             w_pick_erase;
`endif

  for (genvar g = 0; g < NUM_WALLS; g++) begin : g_wall_flat
`ifdef WALL_ERASE_EN
    assign w_busy[g] = (r_state[g] == S_DRAW) || (r_state[g] == S_ERASE);
`else
    assign w_busy[g] = (r_state[g] == S_DRAW);
`endif
    assign w_stop[g] = (r_state[g] == S_STOP);
    // Only the wall currently holding the grant sees the drawer's done pulse.
    assign w_done[g] = r_req && drw.draw_done && (r_id == ID_W'(g));
    assign state_flat[4*g +: 4]         = r_state[g];
    assign pos_flat[POS_W*g +: POS_W]   = r_pos[g];
  end

  assign all_stopped = &w_stop;

  // Per-wall next-state logic.
  always_comb begin
    for (int i = 0; i < NUM_WALLS; i++) begin
      w_state_nx[i] = r_state[i];
      w_after_nx[i] = r_after[i];
      w_pos_nx[i]   = r_pos[i];
      w_hit_nx[i]   = r_hit[i];
`ifdef WALL_ERASE_EN
      w_old_pos_nx[i] = r_old_pos[i];
`endif
      case (r_state[i])
        S_READY: begin
          if (go[i]) begin
            w_state_nx[i] = S_DRAW;
            w_after_nx[i] = S_MOVE;
          end
        end
        S_MOVE: begin
          if (touched[i]) begin
            w_state_nx[i] = S_STOP;
          end else if (tick) begin
            w_pos_nx[i]   = (r_pos[i] < C_STEP) ? C_POS_MAX : r_pos[i] - C_STEP;
            w_after_nx[i] = S_MOVE;
`ifdef WALL_ERASE_EN
            w_old_pos_nx[i] = r_pos[i];
            w_state_nx[i]   = S_ERASE;
`else
            w_state_nx[i]   = S_DRAW;
`endif
          end
        end
        S_DRAW: begin
          if (touched[i]) begin
            w_hit_nx[i] = 1'b1;
          end
          if (w_done[i]) begin
            w_state_nx[i] = r_hit[i] ? S_STOP : r_after[i];
            w_hit_nx[i]   = 1'b0;
          end
        end
`ifdef WALL_ERASE_EN
        S_ERASE: begin
          if (touched[i]) begin
            w_hit_nx[i] = 1'b1;
          end
          if (w_done[i]) begin
            w_state_nx[i] = S_DRAW;
          end
        end
`endif
        S_STOP: begin
          if (restart) begin
            w_state_nx[i] = S_READY;
            w_pos_nx[i]   = C_POS_MAX;
          end
        end
        default: begin
          w_state_nx[i] = S_READY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_WALLS; i++) begin
        r_state[i] <= S_READY;
        r_after[i] <= S_READY;
        r_pos[i]   <= C_POS_MAX;
`ifdef WALL_ERASE_EN
        r_old_pos[i] <= C_POS_MAX;
`endif
      end
      r_hit <= '0;
    end else begin
      for (int i = 0; i < NUM_WALLS; i++) begin
        r_state[i] <= w_state_nx[i];
        r_after[i] <= w_after_nx[i];
        r_pos[i]   <= w_pos_nx[i];
`ifdef WALL_ERASE_EN
        r_old_pos[i] <= w_old_pos_nx[i];
`endif
      end
      r_hit <= w_hit_nx;
    end
  end

  // Round-robin search starting one past the last granted wall.
  always_comb begin
    w_found  = 1'b0;
    w_pick   = '0;
    w_pick_x = '0;
    w_idx    = 0;
`ifdef WALL_ERASE_EN
    w_pick_erase = 1'b0;
`endif
    for (int k = 1; k <= NUM_WALLS; k++) begin
      w_idx = int'(r_rr) + k;
      if (w_idx >= NUM_WALLS) begin
        w_idx = w_idx - NUM_WALLS;
      end
      if (!w_found && w_busy[w_idx]) begin
        w_found  = 1'b1;
        w_pick   = ID_W'(w_idx);
`ifdef WALL_ERASE_EN
        w_pick_erase = (r_state[w_idx] == S_ERASE);
        w_pick_x     = w_pick_erase ? r_old_pos[w_idx] : r_pos[w_idx];
`else
        w_pick_x     = r_pos[w_idx];
`endif
      end
    end
  end

  // A job launches only from idle, which guarantees an idle cycle between jobs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_req <= 1'b0;
      r_id  <= '0;
      r_x   <= '0;
      r_rr  <= C_RR_INIT;
`ifdef WALL_ERASE_EN
      r_erase <= 1'b0;
`endif
    end else if (r_req) begin
      if (drw.draw_done) begin
        r_req <= 1'b0;
      end
    end else if (w_found) begin
      r_req <= 1'b1;
      r_id  <= w_pick;
      r_x   <= w_pick_x;
      r_rr  <= w_pick;
`ifdef WALL_ERASE_EN
      r_erase <= w_pick_erase;
`endif
    end
  end

  assign drw.draw_req = r_req;
  assign drw.draw_id  = r_id;
  assign drw.draw_x   = r_x;
`ifdef WALL_ERASE_EN
  assign drw.draw_erase = r_erase;
`else
  assign drw.draw_erase = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wall_ctrl_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_wall_ctrl_multi                                                   |
// | Directed self-checking bench: 4-wall default instance plus a 1-wall |
// | instance (POS_MAX=104) reaching the exact-STEP and zero wrap points. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_wall_ctrl_multi;

  logic        clk = 1'b0;
  logic        resetn;
  logic        tick;
  logic        restart;
  logic [3:0]  go;
  logic [3:0]  touched;
  logic [15:0] state_flat;
  logic [31:0] pos_flat;
  logic        all_stopped;

  logic        go2;
  logic        touched2;
  logic [3:0]  st2;
  logic [7:0]  pos2;
  logic        all2;

  int n_checks = 0;
  int n_errors = 0;

  wall_ctrl_multi_if #(.ID_W(2), .POS_W(8)) mif ();
  wall_ctrl_multi_if #(.ID_W(1), .POS_W(8)) d2if ();

  always #5 clk = ~clk;

  wall_ctrl_multi #(
    .NUM_WALLS(4), .ID_W(2), .POS_W(8), .POS_MAX(159), .STEP(4)
  ) u_dut (
    .clk(clk), .resetn(resetn), .go(go), .touched(touched), .tick(tick),
    .restart(restart), .drw(mif), .state_flat(state_flat),
    .pos_flat(pos_flat), .all_stopped(all_stopped)
  );

  wall_ctrl_multi #(
    .NUM_WALLS(1), .ID_W(1), .POS_W(8), .POS_MAX(104), .STEP(4)
  ) u_dut2 (
    .clk(clk), .resetn(resetn), .go(go2), .touched(touched2), .tick(tick),
    .restart(restart), .drw(d2if), .state_flat(st2),
    .pos_flat(pos2), .all_stopped(all2)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic serve(input int id, input int x);
    int n;
    n = 0;
    while (mif.draw_req !== 1'b1 && n < 10) begin
      cyc();
      n++;
    end
    chk("serve_req", 64'(mif.draw_req), 64'(1));
    chk("serve_id", 64'(mif.draw_id), 64'(id));
    chk("serve_x", 64'(mif.draw_x), 64'(x));
    chk("serve_erase", 64'(mif.draw_erase), 64'(0));
    cyc();
    mif.draw_done = 1'b1;
    cyc();
    mif.draw_done = 1'b0;
    chk("serve_release", 64'(mif.draw_req), 64'(0));
  endtask

  task automatic serve2(input int x);
    int n;
    n = 0;
    while (d2if.draw_req !== 1'b1 && n < 10) begin
      cyc();
      n++;
    end
    chk("d2_req", 64'(d2if.draw_req), 64'(1));
    chk("d2_x", 64'(d2if.draw_x), 64'(x));
    d2if.draw_done = 1'b1;
    cyc();
    d2if.draw_done = 1'b0;
    chk("d2_release", 64'(d2if.draw_req), 64'(0));
    chk("d2_move", 64'(st2), 64'(4'h6));
  endtask

  initial begin
    resetn = 1'b0; go = '0; touched = '0; tick = 1'b0; restart = 1'b0;
    go2 = 1'b0; touched2 = 1'b0;
    mif.draw_done = 1'b0; d2if.draw_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    cyc();
    chk("rst_state", 64'(state_flat), 64'(16'h5555));
    chk("rst_pos", 64'(pos_flat), 64'(32'h9f9f9f9f));
    chk("rst_req", 64'(mif.draw_req), 64'(0));
    chk("rst_id", 64'(mif.draw_id), 64'(0));
    chk("rst_x", 64'(mif.draw_x), 64'(0));
    chk("rst_allstop", 64'(all_stopped), 64'(0));
    chk("rst2_pos", 64'(pos2), 64'(104));

    // Single-wall instance: walk the full position range through both wrap points.
    go2 = 1'b1;
    cyc();
    go2 = 1'b0;
    chk("d2_go_draw", 64'(st2), 64'(4'h8));
    serve2(104);
    for (int k = 1; k <= 27; k++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      chk("d2_tick_draw", 64'(st2), 64'(4'h8));
      serve2((k <= 26) ? (104 - 4 * k) : 104);
    end
    tick = 1'b1; touched2 = 1'b1;
    cyc();
    tick = 1'b0; touched2 = 1'b0;
    chk("d2_touch_prio_state", 64'(st2), 64'(4'h7));
    chk("d2_touch_prio_pos", 64'(pos2), 64'(104));
    chk("d2_allstop", 64'(all2), 64'(1));
    chk("main_ready_ignores_tick", 64'(state_flat), 64'(16'h5555));

    // Wall 0 alone.
    go = 4'b0001;
    cyc();
    go = '0;
    chk("go0_state", 64'(state_flat), 64'(16'h5558));
    chk("go0_noreq", 64'(mif.draw_req), 64'(0));
    cyc();
    chk("go0_req", 64'(mif.draw_req), 64'(1));
    chk("go0_id", 64'(mif.draw_id), 64'(0));
    chk("go0_x", 64'(mif.draw_x), 64'(159));
    chk("go0_erase", 64'(mif.draw_erase), 64'(0));
    mif.draw_done = 1'b1;
    cyc();
    mif.draw_done = 1'b0;
    chk("go0_done_req", 64'(mif.draw_req), 64'(0));
    chk("go0_move", 64'(state_flat), 64'(16'h5556));

    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("tick0_pos", 64'(pos_flat[7:0]), 64'(155));
    serve(0, 155);

    // Asynchronous reset in the middle of a granted job.
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
    chk("mid_req", 64'(mif.draw_req), 64'(1));
    chk("mid_x", 64'(mif.draw_x), 64'(151));
    resetn = 1'b0;
    #2;
    chk("async_req", 64'(mif.draw_req), 64'(0));
    chk("async_state", 64'(state_flat), 64'(16'h5555));
    chk("async_pos", 64'(pos_flat), 64'(32'h9f9f9f9f));
    @(posedge clk);
    #1;
    resetn = 1'b1;
    cyc();

    // All four walls start together: grants rotate 0..3, and again from 0.
    go = 4'hf;
    cyc();
    go = '0;
    chk("goall_state", 64'(state_flat), 64'(16'h8888));
    for (int j = 0; j < 4; j++) serve(j, 159);
    chk("round1_move", 64'(state_flat), 64'(16'h6666));
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("round2_state", 64'(state_flat), 64'(16'h8888));
    chk("round2_pos", 64'(pos_flat), 64'(32'h9b9b9b9b));
    for (int j = 0; j < 4; j++) serve(j, 155);

    // Collision on wall 1 while it waits in DRAW; a tick in DRAW is ignored.
    tick = 1'b1;
    cyc();
    touched = 4'b0010;
    cyc();
    touched = '0; tick = 1'b0;
    chk("draw_ignores_tick", 64'(pos_flat), 64'(32'h97979797));
    serve(0, 151);
    serve(1, 151);
    chk("hit_stop", 64'(state_flat[7:4]), 64'(4'h7));
    serve(2, 151);
    serve(3, 151);
    chk("hit_states", 64'(state_flat), 64'(16'h6676));
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("skip1_state", 64'(state_flat), 64'(16'h8878));
    serve(0, 147);
    serve(2, 147);
    serve(3, 147);
    repeat (3) cyc();
    chk("no_req_stopped", 64'(mif.draw_req), 64'(0));
    chk("skip1_pos", 64'(pos_flat), 64'(32'h93939793));
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    chk("restart_state", 64'(state_flat), 64'(16'h6656));
    chk("restart_pos", 64'(pos_flat), 64'(32'h93939f93));

    // Bring wall 1 back to MOVE, then stop everything.
    go = 4'b0010;
    cyc();
    go = '0;
    serve(1, 159);
    chk("allmove_state", 64'(state_flat), 64'(16'h6666));
    chk("allmove_nostop", 64'(all_stopped), 64'(0));
    touched = 4'hf;
    cyc();
    touched = '0;
    chk("allstop_state", 64'(state_flat), 64'(16'h7777));
    chk("allstop_flag", 64'(all_stopped), 64'(1));
    mif.draw_done = 1'b1;
    cyc();
    mif.draw_done = 1'b0;
    chk("idle_done_req", 64'(mif.draw_req), 64'(0));
    chk("idle_done_state", 64'(state_flat), 64'(16'h7777));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
